spi_master_fifo: RTL

//  Synchronous single-clock FIFO with valid/ready on both sides. Instantiated twice beside
//  the SPI APB register interface:
//  - TX path: sink of the APB TXFIFO write strobe, drained by the SPI shift controller.
//  - RX path: filled by the shift controller, drained by the APB RXFIFO read strobe.

---
 rtl/spi_master_fifo.sv | 92 +++++++++
 1 files changed

// File: rtl/spi_master_fifo.sv
// Synchronous single-clock FIFO with valid/ready handshakes on both sides.
// Used for the SPI TX and RX data paths. elements_o reports current occupancy.
// Depth may be any value >= 2; pointers wrap explicitly at BUFFER_DEPTH-1.
module spi_master_fifo #(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned BUFFER_DEPTH     = 10,
  parameter int unsigned LOG_BUFFER_DEPTH = $clog2(BUFFER_DEPTH)
) (
  input  logic                        HCLK,
  input  logic                        HRESETn,
  input  logic                        clr_i,
  output logic [LOG_BUFFER_DEPTH:0]   elements_o,
  input  logic [DATA_WIDTH-1:0]       data_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  output logic [DATA_WIDTH-1:0]       data_o,
  output logic                        valid_o,
  input  logic                        ready_i
);

  typedef logic [LOG_BUFFER_DEPTH-1:0] ptr_t;
  typedef logic [LOG_BUFFER_DEPTH:0]   cnt_t;

  localparam ptr_t PTR_LAST = ptr_t'(BUFFER_DEPTH - 1);
  localparam cnt_t CNT_FULL = cnt_t'(BUFFER_DEPTH);

  ptr_t                  rd_ptr_q, rd_ptr_d;
  ptr_t                  wr_ptr_q, wr_ptr_d;
  cnt_t                  elements_q, elements_d;
  logic [DATA_WIDTH-1:0] mem_q [BUFFER_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [BUFFER_DEPTH];
  logic                  push, pop;

  function automatic ptr_t next_ptr(input ptr_t p);
    return (p == PTR_LAST) ? '0 : p + ptr_t'(1);
  endfunction

  // Handshake flags and head word, decoded from registered state only
  always_comb begin
    ready_o    = (elements_q != CNT_FULL);
    valid_o    = (elements_q != '0);
    elements_o = elements_q;
    data_o     = mem_q[rd_ptr_q];
    push       = valid_i & ready_o;
    pop        = valid_o & ready_i;
  end

  // Next-state for pointers and occupancy; flush overrides any transfer
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    elements_d = elements_q;
    if (clr_i) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      elements_d = '0;
    end else begin
      if (push) wr_ptr_d = next_ptr(wr_ptr_q);
      if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);
      case ({push, pop})
        2'b10:   elements_d = elements_q + cnt_t'(1);
        2'b01:   elements_d = elements_q - cnt_t'(1);
        default: elements_d = elements_q;
      endcase
    end
  end

  // Storage next-state: write the incoming word at the write pointer
  always_comb begin
    mem_d = mem_q;
    if (push && !clr_i) mem_d[wr_ptr_q] = data_i;
  end

  // Control state registers with synchronous active-low reset
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      elements_q <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      elements_q <= elements_d;
    end
  end

  // Storage array is intentionally not reset
  always_ff @(posedge HCLK) begin
    mem_q <= mem_d;
  end

endmodule
